perf_counter_bank: RTL and testbench

- Parametrised bank of NUM_CH event counters, each CNT_WIDTH bits wide, read and written through a 32-bit register port in low/high halves.
- Extends the simple single counter: per-channel enable, per-channel wrap or saturate mode, global freeze, sticky overflow flags with an interrupt, and a shadow register that gives tear-free 64-bit reads.
- Serves the core's mcycle/minstret/hpmcounter CSR datapath.

---
 rtl/perf_counter_bank_if.sv | 26 ++
 rtl/perf_counter_bank.sv | 120 ++++++++++++
 tb/tb_perf_counter_bank.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// Register-port bundle for perf_counter_bank: channel select, half select,
// write strobe/data, read strobe, and the registered read data/valid return.
// Ports: master drives sel_ch/sel_hi/wr_en/wr_data/rd_en; slave returns rd_data/rd_valid.
interface perf_counter_bank_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0] sel_ch;
  logic            sel_hi;
  logic            wr_en;
  logic [31:0]     wr_data;
  logic            rd_en;
  logic [31:0]     rd_data;
  logic            rd_valid;

  modport master (
    output sel_ch, sel_hi, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sel_ch, sel_hi, wr_en, wr_data, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Purpose: bank of NUM_CH event counters (wrap/saturate, sticky overflow + irq),
//          accessed as 32-bit halves with a single shadow for tear-free 64-bit reads.
// Latency: reads return one cycle after rd_en; writes/increments land at the next edge.
// Backpressure: none; a read may be issued every cycle and always completes.
// Ports: clk/resetn; bus (register port, slave); inc/ch_en/freeze/sat_mode/irq_en/ovf_clr
//        per-channel controls; ovf sticky flags; irq = |(ovf & irq_en).
module perf_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 64
) (
  input  logic              clk,
  input  logic              resetn,
  perf_counter_bank_if.slave bus,
  input  logic [NUM_CH-1:0] inc,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              freeze,
  input  logic [NUM_CH-1:0] sat_mode,
  input  logic [NUM_CH-1:0] irq_en,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic [NUM_CH-1:0] ovf,
  output logic              irq
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HI_W = CNT_WIDTH - 32;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("perf_counter_bank: NUM_CH must be 1..16");
  end
  if (CNT_WIDTH < 33 || CNT_WIDTH > 64) begin : g_bad_cnt_width
    $error("perf_counter_bank: CNT_WIDTH must be 33..64");
  end

  logic [CNT_WIDTH-1:0] cnt     [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]    ovf_nxt;
  logic [NUM_CH-1:0]    ev;
  logic [NUM_CH-1:0]    wr_hit;
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic                 sel_ok;
  logic                 wr_ok;

  logic [HI_W-1:0]      shadow_hi;
  logic [CH_W-1:0]      shadow_ch;
  logic                 shadow_valid;

  assign ev     = inc & ch_en & {NUM_CH{~freeze}};
  assign sel_ok = int'(bus.sel_ch) < NUM_CH;
  assign wr_ok  = bus.wr_en && sel_ok;
  assign irq    = |(ovf & irq_en);

  // Loop-based select keeps out-of-range sel_ch from indexing past the array.
  always_comb begin
    sel_cnt = '0;
    wr_hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == bus.sel_ch) begin
        sel_cnt   = cnt[i];
        wr_hit[i] = bus.wr_en;
      end
    end
  end

  always_comb begin
    ovf_nxt = ovf;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = cnt[i];
      // A write starts from the old value, so a same-cycle increment is dropped.
      if (wr_hit[i]) begin
        if (bus.sel_hi) cnt_nxt[i][CNT_WIDTH-1:32] = bus.wr_data[HI_W-1:0];
        else            cnt_nxt[i][31:0]           = bus.wr_data;
      end else if (ev[i]) begin
        if (!(&cnt[i]))        cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        else if (!sat_mode[i]) cnt_nxt[i] = '0;
      end
      if (ovf_clr[i] || wr_hit[i]) ovf_nxt[i] = 1'b0;
      // Set wins over clear; saturated counters re-flag on each qualifying event.
      if (ev[i] && (&cnt[i]))      ovf_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
      ovf <= ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      shadow_hi    <= '0;
      shadow_ch    <= '0;
      shadow_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        if (!sel_ok) begin
          bus.rd_data <= '0;
        end else if (!bus.sel_hi) begin
          bus.rd_data  <= sel_cnt[31:0];
          shadow_hi    <= sel_cnt[CNT_WIDTH-1:32];
          shadow_ch    <= bus.sel_ch;
          shadow_valid <= 1'b1;
        end else if (shadow_valid && shadow_ch == bus.sel_ch) begin
          bus.rd_data  <= 32'(shadow_hi);
          shadow_valid <= 1'b0;
        end else begin
          bus.rd_data <= 32'(sel_cnt[CNT_WIDTH-1:32]);
        end
      end
      // A write invalidates a stale snapshot, including one captured this same cycle.
      if (wr_ok && (shadow_ch == bus.sel_ch || (bus.rd_en && !bus.sel_hi)))
        shadow_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: scoreboard queue of expected read data, popped when
// rd_valid is seen; rd_valid timing and rd_data hold are checked every cycle.
module tb_perf_counter_bank;
  localparam int NUM_CH = 4;

  logic              clk;
  logic              resetn;
  logic [NUM_CH-1:0] inc, ch_en, sat_mode, irq_en, ovf_clr, ovf;
  logic              freeze, irq;

  perf_counter_bank_if #(.NUM_CH(NUM_CH)) bus ();

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(64)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .inc      (inc),
    .ch_en    (ch_en),
    .freeze   (freeze),
    .sat_mode (sat_mode),
    .irq_en   (irq_en),
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .irq      (irq)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic        exp_rdv  = 1'b0;
  logic [31:0] last_exp = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Expected rd_valid follows rd_en by one edge; reset drops anything in flight.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_rdv  = 1'b0;
      last_exp = '0;
      exp_q.delete();
    end else begin
      exp_rdv = bus.rd_en;
    end
  end

  always @(negedge clk) begin
    check_val("rd_valid", {63'd0, bus.rd_valid}, {63'd0, exp_rdv});
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check_val("rd_unexpected", 64'd1, 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check_val("rd_data", {32'd0, bus.rd_data}, {32'd0, last_exp});
      end
    end else begin
      check_val("rd_hold", {32'd0, bus.rd_data}, {32'd0, last_exp});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic hi, input logic [31:0] data);
    bus.sel_ch  = 2'(ch);
    bus.sel_hi  = hi;
    bus.wr_data = data;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input int ch, input logic hi, input logic [31:0] exp);
    bus.sel_ch = 2'(ch);
    bus.sel_hi = hi;
    bus.rd_en  = 1'b1;
    exp_q.push_back(exp);
    step();
    bus.rd_en  = 1'b0;
  endtask

  task automatic pulse_inc(input logic [NUM_CH-1:0] m, input int n);
    inc = m;
    for (int k = 0; k < n; k++) step();
    inc = '0;
  endtask

  initial begin
    resetn = 1'b0;
    inc = '0; ch_en = '0; sat_mode = '0; irq_en = '0; ovf_clr = '0; freeze = 1'b0;
    bus.sel_ch = '0; bus.sel_hi = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();
    check_val("rst_rd_data", {32'd0, bus.rd_data}, 64'd0);
    check_val("rst_ovf", {60'd0, ovf}, 64'd0);
    check_val("rst_irq", {63'd0, irq}, 64'd0);

    // Basic count and 64-bit read.
    ch_en = 4'hF;
    pulse_inc(4'b0001, 5);
    rd(0, 1'b0, 32'h0000_0005);
    rd(0, 1'b1, 32'h0000_0000);

    // Wrap with overflow and interrupt.
    wr(1, 1'b1, 32'hFFFF_FFFF);
    wr(1, 1'b0, 32'hFFFF_FFFE);
    irq_en = 4'b0010;
    pulse_inc(4'b0010, 2);
    check_val("wrap_ovf", {63'd0, ovf[1]}, 64'd1);
    check_val("wrap_irq", {63'd0, irq}, 64'd1);
    rd(1, 1'b0, 32'h0000_0000);
    rd(1, 1'b1, 32'h0000_0000);
    ovf_clr = 4'b0010; step(); ovf_clr = '0;
    check_val("clr_ovf", {63'd0, ovf[1]}, 64'd0);
    check_val("clr_irq", {63'd0, irq}, 64'd0);

    // Saturate.
    wr(2, 1'b1, 32'hFFFF_FFFF);
    wr(2, 1'b0, 32'hFFFF_FFFE);
    sat_mode = 4'b0100;
    pulse_inc(4'b0100, 3);
    check_val("sat_ovf", {63'd0, ovf[2]}, 64'd1);
    rd(2, 1'b0, 32'hFFFF_FFFF);
    rd(2, 1'b1, 32'hFFFF_FFFF);
    // Overflow event beats a same-cycle clear; a lone clear then works.
    inc = 4'b0100; ovf_clr = 4'b0100; step(); inc = '0; ovf_clr = '0;
    check_val("set_beats_clr", {63'd0, ovf[2]}, 64'd1);
    ovf_clr = 4'b0100; step(); ovf_clr = '0;
    check_val("sat_clr", {63'd0, ovf[2]}, 64'd0);

    // Tear-free read through the shadow.
    wr(0, 1'b1, 32'h0000_0000);
    wr(0, 1'b0, 32'hFFFF_FFFF);
    rd(0, 1'b0, 32'hFFFF_FFFF);
    pulse_inc(4'b0001, 1);
    rd(0, 1'b1, 32'h0000_0000);
    rd(0, 1'b1, 32'h0000_0001);

    // Write + low read same cycle: old data returned, no snapshot kept.
    bus.sel_ch = 2'd0; bus.sel_hi = 1'b0; bus.wr_data = 32'hFFFF_FFFF;
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; exp_q.push_back(32'h0000_0000);
    step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    pulse_inc(4'b0001, 1);
    rd(0, 1'b1, 32'h0000_0002);

    // Write beats increment; freeze and ch_en inhibit counting.
    inc = 4'b1000;
    wr(3, 1'b0, 32'h0000_0010);
    inc = '0;
    rd(3, 1'b0, 32'h0000_0010);
    freeze = 1'b1;
    pulse_inc(4'b1000, 2);
    freeze = 1'b0;
    ch_en = 4'b0111;
    pulse_inc(4'b1000, 2);
    ch_en = 4'hF;
    rd(3, 1'b0, 32'h0000_0010);

    // Async reset mid-count with a read outstanding.
    irq_en = 4'b0100;
    pulse_inc(4'b0100, 1);
    check_val("pre_rst_irq", {63'd0, irq}, 64'd1);
    inc = 4'b0001;
    bus.sel_ch = 2'd0; bus.sel_hi = 1'b0; bus.rd_en = 1'b1;
    step();
    #2 resetn = 1'b0;
    #1;
    check_val("arst_ovf", {60'd0, ovf}, 64'd0);
    check_val("arst_irq", {63'd0, irq}, 64'd0);
    check_val("arst_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
    check_val("arst_rd_data", {32'd0, bus.rd_data}, 64'd0);
    bus.rd_en = 1'b0; inc = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    pulse_inc(4'b0001, 3);
    rd(0, 1'b0, 32'h0000_0003);
    rd(0, 1'b1, 32'h0000_0000);
    rd(2, 1'b0, 32'h0000_0000);
    step(); step();
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
